// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU controller: one result bit per clock, LSB first, with a start/busy/done handshake.
// Optional zero/ovf flag outputs are enabled by defining ALU_SERIAL_FLAGS_EN.
module alu_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
`ifdef ALU_SERIAL_FLAGS_EN
  ,
  output logic             zero,
  output logic             ovf
`endif
);

  localparam int unsigned   CW   = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } op_t;

  state_t           state, state_next;
  op_t              op_q;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh, res_next;
  logic [CW-1:0]    cnt;
  logic             carry, carry_next;
  logic             accept, last;
  logic             abit, bbit, slice_bit, arith;

  assign busy = (state == RUN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST) begin
          last       = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // SUB is a + ~b + 1: b is inverted here and the +1 comes from the preset carry.
  always_comb begin
    abit       = a_sh[0];
    bbit       = b_sh[0] ^ (op_q == OP_SUB);
    arith      = (op_q == OP_ADD) || (op_q == OP_SUB);
    carry_next = (abit & bbit) | (abit & carry) | (bbit & carry);
    slice_bit  = abit ^ bbit ^ carry;
    case (op_q)
      OP_NOR:  slice_bit = ~(abit | bbit);
      OP_XOR:  slice_bit = abit ^ bbit;
      default: slice_bit = abit ^ bbit ^ carry;
    endcase
    res_next = {slice_bit, res_sh[WIDTH-1:1]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_NOR;
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      cout   <= 1'b0;
`ifdef ALU_SERIAL_FLAGS_EN
      zero   <= 1'b0;
      ovf    <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (accept) begin
        op_q  <= op_t'(op);
        a_sh  <= a;
        b_sh  <= b;
        cnt   <= '0;
        carry <= (op_t'(op) == OP_SUB);
      end else if (state == RUN) begin
        a_sh   <= a_sh >> 1;
        b_sh   <= b_sh >> 1;
        res_sh <= res_next;
        cnt    <= cnt + CW'(1);
        if (arith) carry <= carry_next;
        if (last) begin
          done   <= 1'b1;
          result <= res_next;
          cout   <= arith & carry_next;
`ifdef ALU_SERIAL_FLAGS_EN
          // carry still holds the carry into the MSB on this edge
          zero   <= (res_next == '0);
          ovf    <= arith & (carry ^ carry_next);
`endif
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Scoreboard bench for alu_serial_ctrl (WIDTH=8); flag checks compile in with ALU_SERIAL_FLAGS_EN.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [1:0]   op = 2'b00;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         busy, done, cout;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_FLAGS_EN
  logic         zero, ovf;
`endif

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout)
`ifdef ALU_SERIAL_FLAGS_EN
    , .zero(zero), .ovf(ovf)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    logic         z;
    logic         v;
    int unsigned  acc;
  } exp_t;

  exp_t        sb[$];
  int unsigned done_cyc[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned n_acc = 0;
  int unsigned n_abort = 0;
  int unsigned n_done = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t       e;
    logic [W:0] s;
    e.c = 1'b0;
    e.v = 1'b0;
    case (o)
      2'b00: e.res = ~(x | y);
      2'b01: e.res = x ^ y;
      2'b10: begin
        s     = {1'b0, x} + {1'b0, y};
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] == y[W-1]) && (e.res[W-1] != x[W-1]);
      end
      default: begin
        s     = {1'b0, x} + {1'b0, ~y} + 1;
        e.res = s[W-1:0];
        e.c   = s[W];
        e.v   = (x[W-1] != y[W-1]) && (e.res[W-1] != x[W-1]);
      end
    endcase
    e.z   = (e.res == '0);
    e.acc = 0;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: pops expectations on done, checks latency, pulse width and result holding.
  exp_t         em;
  logic [W-1:0] held = '0;
  logic         done_prev = 1'b0;
  int unsigned  busy_run = 0;

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      held      = '0;
      busy_run  = 0;
      done_prev = 1'b0;
    end else begin
      if (done) begin
        n_done++;
        done_cyc.push_back(cyc);
        check("done_width", {63'd0, done_prev}, 64'd0);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        check("busy_len", busy_run, W);
        if (sb.size() == 0) begin
          check("spurious_done", 64'd1, 64'd0);
        end else begin
          em = sb.pop_front();
          check("result", result, em.res);
          check("cout", {63'd0, cout}, {63'd0, em.c});
          check("latency", cyc - em.acc, W);
`ifdef ALU_SERIAL_FLAGS_EN
          check("zero", {63'd0, zero}, {63'd0, em.z});
          check("ovf", {63'd0, ovf}, {63'd0, em.v});
`endif
          held = em.res;
        end
        busy_run = 0;
      end else begin
        check("result_hold", result, held);
      end
      if (busy) busy_run++;
      done_prev = done;
    end
  end

  task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, input bit hold);
    exp_t        e;
    int unsigned n;
    op    = o;
    a     = x;
    b     = y;
    start = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 100);
    if (n >= 100) check("accept_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
    e     = model(o, x, y);
    e.acc = cyc;
    sb.push_back(e);
    n_acc++;
    if (!hold) start = 1'b0;
  endtask

  task automatic drain;
    int unsigned n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("drain_timeout", 64'd1, 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", result, '0);
    check("rst_cout", {63'd0, cout}, 64'd0);
    rst = 1'b0;

    issue(2'b10, 8'h3C, 8'h45, 1'b0); drain();
    issue(2'b11, 8'h10, 8'h20, 1'b0); drain();
    issue(2'b11, 8'h80, 8'h01, 1'b0); drain();
    issue(2'b00, 8'hF0, 8'h0F, 1'b0); drain();
    issue(2'b01, 8'hAA, 8'hFF, 1'b0); drain();

    // start pulse during a running ADD must be ignored; operand changes too
    issue(2'b10, 8'h3C, 8'h45, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1; a = 8'h01; b = 8'h01; op = 2'b10;
    @(posedge clk);
    #1;
    start = 1'b0;
    drain();

    // reset mid-operation aborts without a done pulse
    issue(2'b10, 8'h77, 8'h11, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    n_abort++;
    @(posedge clk);
    #1;
    check("abort_busy", {63'd0, busy}, 64'd0);
    check("abort_done", {63'd0, done}, 64'd0);
    check("abort_result", result, '0);
    rst = 1'b0;
    issue(2'b10, 8'h01, 8'hFF, 1'b0); drain();

    // rst and start together: reset wins
    rst = 1'b1; start = 1'b1; op = 2'b10; a = 8'h05; b = 8'h06;
    @(posedge clk);
    #1;
    check("rst_start_busy", {63'd0, busy}, 64'd0);
    start = 1'b0; rst = 1'b0;
    @(posedge clk);
    #1;

    // start held high: back-to-back accepts in each done cycle
    done_cyc.delete();
    issue(2'b10, 8'h3C, 8'h45, 1'b1);
    issue(2'b10, 8'h12, 8'h34, 1'b1);
    issue(2'b10, 8'hFF, 8'h01, 1'b0);
    drain();
    if (done_cyc.size() == 3) begin
      check("spacing1", done_cyc[1] - done_cyc[0], W + 1);
      check("spacing2", done_cyc[2] - done_cyc[1], W + 1);
    end else begin
      check("b2b_dones", done_cyc.size(), 3);
    end

    for (int i = 0; i < 8; i++) begin
      issue(2'($urandom_range(3)), W'($urandom), W'($urandom), 1'b0);
      drain();
    end

    check("done_count", n_done, n_acc - n_abort);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
